mem_bus_unit: RTL and testbench

Memory-mapped bus slave directly downstream of the `cpu` core. It decodes the core's `CS`/`WR_RD`/`ADDR` bus into a synchronous word RAM and a small I/O region. The I/O region holds:
- a free-running cycle counter;
- a status register;
- a buffered output port drained by an external ready/valid consumer.

Read data returns on `Data_BUS_READ`, one clock after the request.

---
 rtl/mem_bus_pkg.sv | 17 +
 rtl/out_fifo.sv | 96 +++++++++
 rtl/mem_bus_unit.sv | 121 ++++++++++++
 tb/tb_mem_bus_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared constants for the memory-mapped bus slave: I/O decode, register
// offsets, STATUS bit layout and the bus data width.
package mem_bus_pkg;

    localparam int DATA_W     = 32;
    localparam int IO_SEL_BIT = 31;

    localparam logic [1:0] OFS_CYCLE   = 2'd0;
    localparam logic [1:0] OFS_OUTPORT = 2'd1;
    localparam logic [1:0] OFS_STATUS  = 2'd2;
    localparam logic [1:0] OFS_SCRATCH = 2'd3;

    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_OVF_BIT   = 2;

endpackage

// File: rtl/out_fifo.sv
// Output port buffer drained by a ready/valid consumer.
// Build option OUTPUT_FIFO_EN: when defined, a FIFO_DEPTH-entry circular
// buffer; when undefined, a single holding register (FIFO_DEPTH unused).
import mem_bus_pkg::*;

module out_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              full,
    output logic              push_accepted
);

    logic pop;

`ifdef OUTPUT_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    // Handshake decode; a push into a full buffer is only taken when the head leaves this cycle
    always_comb begin
        out_valid     = (count != '0);
        full          = (count == CW'(FIFO_DEPTH));
        pop           = out_valid && pop_ready;
        push_accepted = push && (!full || pop);
        out_data      = out_valid ? mem[rd_ptr] : '0;
    end

    // Storage write; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (push_accepted)
            mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping, pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_accepted)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_accepted, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
`else
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              unused_depth;

    assign unused_depth = ^FIFO_DEPTH;

    // Single-entry handshake: accept when empty or when the held word leaves
    always_comb begin
        out_valid     = valid_q;
        full          = valid_q;
        pop           = valid_q && pop_ready;
        push_accepted = push && (!valid_q || pop);
        out_data      = data_q;
    end

    // Holding register and its valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push_accepted) begin
                data_q  <= push_data;
                valid_q <= 1'b1;
            end else if (pop) begin
                valid_q <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_bus_unit.sv
// Bus slave behind the cpu core: word RAM plus an I/O region holding a cycle
// counter, STATUS, SCRATCH and a buffered output port.
// Build option OUTPUT_FIFO_EN selects a multi-entry output FIFO instead of a
// single holding register.
import mem_bus_pkg::*;

module mem_bus_unit #(
    parameter int RAM_AW     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              CS,
    input  logic              WR_RD,
    input  logic [31:0]       ADDR,
    input  logic [DATA_W-1:0] Data_BUS_WRITE,
    output logic [DATA_W-1:0] Data_BUS_READ,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic              Fifo_Full
);

    logic [DATA_W-1:0] ram [2**RAM_AW];
    logic [DATA_W-1:0] cycle_count;
    logic [DATA_W-1:0] scratch;
    logic              overflow;

    logic              is_io;
    logic [1:0]        io_ofs;
    logic [RAM_AW-1:0] ram_idx;
    logic              bus_wr;
    logic              bus_rd;
    logic              ram_we;
    logic              scratch_we;
    logic              push_req;
    logic              push_accepted;
    logic              status_rd;
    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] read_mux;
    logic              unused_addr;

    assign unused_addr = ^{ADDR[30:RAM_AW+2], ADDR[1:0]};

    // Address decode into per-target strobes
    always_comb begin
        is_io      = ADDR[IO_SEL_BIT];
        io_ofs     = ADDR[3:2];
        ram_idx    = ADDR[RAM_AW+1:2];
        bus_wr     = CS && WR_RD;
        bus_rd     = CS && !WR_RD;
        ram_we     = bus_wr && !is_io;
        scratch_we = bus_wr && is_io && (io_ofs == OFS_SCRATCH);
        push_req   = bus_wr && is_io && (io_ofs == OFS_OUTPORT);
        status_rd  = bus_rd && is_io && (io_ofs == OFS_STATUS);
    end

    out_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk           (Clk),
        .rst_n         (Reset),
        .push          (push_req),
        .push_data     (Data_BUS_WRITE),
        .pop_ready     (Out_Ready),
        .out_data      (Out_Data),
        .out_valid     (Out_Valid),
        .full          (Fifo_Full),
        .push_accepted (push_accepted)
    );

    // STATUS view of the registered buffer state and sticky overflow
    always_comb begin
        status_word               = '0;
        status_word[ST_EMPTY_BIT] = !Out_Valid;
        status_word[ST_FULL_BIT]  = Fifo_Full;
        status_word[ST_OVF_BIT]   = overflow;
    end

    // Read-data source selection; OUTPORT reads as zero
    always_comb begin
        read_mux = '0;
        if (!is_io) begin
            read_mux = ram[ram_idx];
        end else begin
            case (io_ofs)
                OFS_CYCLE:   read_mux = cycle_count;
                OFS_STATUS:  read_mux = status_word;
                OFS_SCRATCH: read_mux = scratch;
                default:     read_mux = '0;
            endcase
        end
    end

    // Word RAM, contents survive reset
    always_ff @(posedge Clk) begin
        if (ram_we)
            ram[ram_idx] <= Data_BUS_WRITE;
    end

    // Counter, SCRATCH, sticky overflow and the registered read data
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cycle_count   <= '0;
            scratch       <= '0;
            overflow      <= 1'b0;
            Data_BUS_READ <= '0;
        end else begin
            cycle_count <= cycle_count + 1'b1;
            if (scratch_we)
                scratch <= Data_BUS_WRITE;
            if (push_req && !push_accepted)
                overflow <= 1'b1;
            else if (status_rd)
                overflow <= 1'b0;
            if (bus_rd)
                Data_BUS_READ <= read_mux;
        end
    end

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed self-checking bench for mem_bus_unit; the output-port section
// follows whichever buffer variant OUTPUT_FIFO_EN selects.
module tb_mem_bus_unit;

    logic        Clk;
    logic        Reset;
    logic        CS;
    logic        WR_RD;
    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic [31:0] Data_BUS_READ;
    logic [31:0] Out_Data;
    logic        Out_Valid;
    logic        Out_Ready;
    logic        Fifo_Full;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] A_CYCLE   = 32'h8000_0000;
    localparam logic [31:0] A_OUTPORT = 32'h8000_0004;
    localparam logic [31:0] A_STATUS  = 32'h8000_0008;
    localparam logic [31:0] A_SCRATCH = 32'h8000_000C;

    mem_bus_unit #(
        .RAM_AW     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .CS             (CS),
        .WR_RD          (WR_RD),
        .ADDR           (ADDR),
        .Data_BUS_WRITE (Data_BUS_WRITE),
        .Data_BUS_READ  (Data_BUS_READ),
        .Out_Data       (Out_Data),
        .Out_Valid      (Out_Valid),
        .Out_Ready      (Out_Ready),
        .Fifo_Full      (Fifo_Full)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One bus request presented across a single rising edge; returns at the following falling edge
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        CS             = 1'b1;
        WR_RD          = wr;
        ADDR           = addr;
        Data_BUS_WRITE = data;
        @(negedge Clk);
        CS             = 1'b0;
        WR_RD          = 1'b0;
    endtask

    // Directed sequence
    initial begin
        logic [31:0] drain_exp [4];

        Reset          = 1'b0;
        CS             = 1'b0;
        WR_RD          = 1'b0;
        ADDR           = '0;
        Data_BUS_WRITE = '0;
        Out_Ready      = 1'b0;
        repeat (2) @(negedge Clk);

        checkOutput("reset_read",  Data_BUS_READ, 32'h0);
        checkOutput("reset_odata", Out_Data, 32'h0);
        checkOutput("reset_valid", {31'b0, Out_Valid}, 32'h0);
        checkOutput("reset_full",  {31'b0, Fifo_Full}, 32'h0);
        Reset = 1'b1;
        @(negedge Clk);

        applyStimulus(1'b0, A_STATUS, 32'h0);
        checkOutput("status_idle", Data_BUS_READ, 32'h1);

        // RAM round trip and aliasing
        applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0);
        checkOutput("ram_read", Data_BUS_READ, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h0000_0410, 32'h0);
        checkOutput("ram_alias", Data_BUS_READ, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 32'h0000_0020, 32'h1234_5678);
        checkOutput("read_hold", Data_BUS_READ, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h0000_0020, 32'h0);
        checkOutput("ram_read2", Data_BUS_READ, 32'h1234_5678);

        // SCRATCH, ignored writes, write-only OUTPORT
        applyStimulus(1'b1, A_SCRATCH, 32'h0000_A5A5);
        applyStimulus(1'b0, A_SCRATCH, 32'h0);
        checkOutput("scratch_rw", Data_BUS_READ, 32'h0000_A5A5);
        applyStimulus(1'b1, A_STATUS, 32'hFFFF_FFFF);
        applyStimulus(1'b0, A_STATUS, 32'h0);
        checkOutput("status_wr_ignored", Data_BUS_READ, 32'h1);
        applyStimulus(1'b0, A_OUTPORT, 32'h0);
        checkOutput("outport_read", Data_BUS_READ, 32'h0);

        // Counter wrap from a preloaded value
        force dut.cycle_count = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_count;
        applyStimulus(1'b0, A_CYCLE, 32'h0);
        checkOutput("cycle_fffe", Data_BUS_READ, 32'hFFFF_FFFE);
        applyStimulus(1'b0, A_CYCLE, 32'h0);
        checkOutput("cycle_ffff", Data_BUS_READ, 32'hFFFF_FFFF);
        applyStimulus(1'b0, A_CYCLE, 32'h0);
        checkOutput("cycle_wrap", Data_BUS_READ, 32'h0);

`ifdef OUTPUT_FIFO_EN
        // Fill the FIFO, overflow on the fifth push
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, A_OUTPORT, 32'(i));
            if (i == 1) begin
                checkOutput("fifo_first_valid", {31'b0, Out_Valid}, 32'h1);
                checkOutput("fifo_first_data",  Out_Data, 32'h1);
            end
            if (i == 3)
                checkOutput("fifo_not_full_3", {31'b0, Fifo_Full}, 32'h0);
            if (i == 4)
                checkOutput("fifo_full_4", {31'b0, Fifo_Full}, 32'h1);
        end
        applyStimulus(1'b0, A_STATUS, 32'h0);
        checkOutput("status_ovf", Data_BUS_READ, 32'h6);
        applyStimulus(1'b0, A_STATUS, 32'h0);
        checkOutput("status_ovf_clr", Data_BUS_READ, 32'h2);

        // Push while full with a simultaneous pop, then drain
        checkOutput("head_before_pop", Out_Data, 32'h1);
        Out_Ready = 1'b1;
        applyStimulus(1'b1, A_OUTPORT, 32'h9);
        drain_exp = '{32'h2, 32'h3, 32'h4, 32'h9};
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_data",  Out_Data, drain_exp[i]);
            checkOutput("drain_valid", {31'b0, Out_Valid}, 32'h1);
            @(negedge Clk);
        end
        checkOutput("drain_empty", {31'b0, Out_Valid}, 32'h0);
        Out_Ready = 1'b0;
        applyStimulus(1'b0, A_STATUS, 32'h0);
        checkOutput("status_no_ovf", Data_BUS_READ, 32'h1);
`else
        // Single holding register: second push is rejected
        applyStimulus(1'b1, A_OUTPORT, 32'h11);
        checkOutput("hold_valid", {31'b0, Out_Valid}, 32'h1);
        checkOutput("hold_full",  {31'b0, Fifo_Full}, 32'h1);
        checkOutput("hold_data",  Out_Data, 32'h11);
        applyStimulus(1'b1, A_OUTPORT, 32'h22);
        checkOutput("hold_keep_first", Out_Data, 32'h11);
        applyStimulus(1'b0, A_STATUS, 32'h0);
        checkOutput("status_ovf", Data_BUS_READ, 32'h6);
        applyStimulus(1'b0, A_STATUS, 32'h0);
        checkOutput("status_ovf_clr", Data_BUS_READ, 32'h2);

        // Push while full with a simultaneous pop
        Out_Ready = 1'b1;
        applyStimulus(1'b1, A_OUTPORT, 32'h33);
        checkOutput("hold_replace_data",  Out_Data, 32'h33);
        checkOutput("hold_replace_valid", {31'b0, Out_Valid}, 32'h1);
        applyStimulus(1'b0, A_STATUS, 32'h0);
        checkOutput("status_no_ovf", Data_BUS_READ, 32'h2);
        checkOutput("hold_drained", {31'b0, Out_Valid}, 32'h0);
        Out_Ready = 1'b0;
`endif

        // Reset in the middle of activity
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, A_OUTPORT, 32'h44 + 32'(i));
        applyStimulus(1'b1, A_SCRATCH, 32'h55);
        applyStimulus(1'b0, A_SCRATCH, 32'h0);
        checkOutput("pre_reset_read", Data_BUS_READ, 32'h55);
        Reset = 1'b0;
        #1;
        checkOutput("mid_reset_read",  Data_BUS_READ, 32'h0);
        checkOutput("mid_reset_odata", Out_Data, 32'h0);
        checkOutput("mid_reset_valid", {31'b0, Out_Valid}, 32'h0);
        checkOutput("mid_reset_full",  {31'b0, Fifo_Full}, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        applyStimulus(1'b0, A_SCRATCH, 32'h0);
        checkOutput("scratch_after_reset", Data_BUS_READ, 32'h0);
        applyStimulus(1'b0, A_STATUS, 32'h0);
        checkOutput("status_after_reset", Data_BUS_READ, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
